// File: rtl/lmac_regrd_pkg.sv
// Shared types and constants for the LMAC register-read arbiter.
package lmac_regrd_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    // Data returned to the owner when the MAC never answers.
    localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last winner.
module rr_arbiter #(
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Take the first requester found in rotated priority order.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = IDX_W'((32'(last_grant) + off) % NREQ);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/lmac_regrd_arbiter.sv
// Shares the single LMAC register-read port among NREQ requesters, one read at a time.
module lmac_regrd_arbiter
    import lmac_regrd_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      host_addr_reg,
    output logic                   reg_rd_start,
    input  logic                   reg_rd_done_out,
    input  logic [DATA_W-1:0]      FMAC_REGDOUT,
    output logic [15:0]            timeout_cnt
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic [NREQ-1:0]     grant;
    logic [IDX_W-1:0]    grant_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .enable     (state_q == IDLE),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign req_ready   = grant;
    assign timeout_cnt = tcnt_q;

    // State and transaction registers; reset abandons any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state logic: accept, issue, wait for done or timeout, respond.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (grant[i]) addr_d = req_addr[i*ADDR_W +: ADDR_W];
                    end
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done takes priority over a coinciding timeout.
                if (reg_rd_done_out) begin
                    data_d  = FMAC_REGDOUT;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    data_d  = ERR_DATA;
                    err_d   = 1'b1;
                    if (tcnt_q != '1) tcnt_d = tcnt_q + 16'd1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state; response fields are zero outside RESP.
    always_comb begin
        reg_rd_start  = (state_q == ISSUE);
        host_addr_reg = (state_q == ISSUE || state_q == WAIT) ? addr_q : '0;
        rsp_valid     = '0;
        rsp_data      = '0;
        rsp_err       = 1'b0;
        if (state_q == RESP) begin
            rsp_valid[owner_q] = 1'b1;
            rsp_data           = data_q;
            rsp_err            = err_q;
        end
    end

endmodule

// File: tb/tb_lmac_regrd_arbiter.sv
// Self-checking bench for lmac_regrd_arbiter: directed scenarios plus a randomized
// run against a transaction-timeline reference model.
module tb_lmac_regrd_arbiter;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned TIMEOUT = 8;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*16-1:0]   req_addr;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_err;
    logic [15:0]          host_addr_reg;
    logic                 reg_rd_start;
    logic                 done;
    logic [31:0]          fmac;
    logic [15:0]          timeout_cnt;

    int checks = 0;
    int errors = 0;

    lmac_regrd_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .host_addr_reg   (host_addr_reg),
        .reg_rd_start    (reg_rd_start),
        .reg_rd_done_out (done),
        .FMAC_REGDOUT    (fmac),
        .timeout_cnt     (timeout_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1);
    end

    function automatic logic [NREQ*16-1:0] rand_addrs();
        logic [NREQ*16-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) v[i*16 +: 16] = 16'($urandom());
        return v;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_addr = '0; done = 1'b0; fmac = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk); #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 ||
            host_addr_reg !== '0 || reg_rd_start !== 1'b0 || timeout_cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b data=%h err=%b addr=%h start=%b tcnt=%0d, required all zero",
                     req_ready, rsp_valid, rsp_data, rsp_err, host_addr_reg, reg_rd_start, timeout_cnt);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        @(negedge clk);
        req_valid = 3'b001; req_addr = rand_addrs(); req_addr[15:0] = 16'h0040; #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL single_ready: got %b, required 001", req_ready);
        end
        @(negedge clk);
        req_valid = '0; req_addr = rand_addrs(); #1;
        checks++;
        if (reg_rd_start !== 1'b1 || host_addr_reg !== 16'h0040) begin
            errors++; $display("FAIL single_issue: start=%b addr=%h, required 1 / 0040", reg_rd_start, host_addr_reg);
        end
        @(negedge clk);
        done = 1'b1; fmac = 32'h1234_5678; #1;
        checks++;
        if (reg_rd_start !== 1'b0 || host_addr_reg !== 16'h0040 || rsp_valid !== '0) begin
            errors++; $display("FAIL single_wait: start=%b addr=%h rsp_valid=%b, required 0 / 0040 / 000",
                               reg_rd_start, host_addr_reg, rsp_valid);
        end
        @(negedge clk);
        done = 1'b0; fmac = $urandom(); #1;
        checks++;
        if (rsp_valid !== 3'b001 || rsp_data !== 32'h1234_5678 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_resp: valid=%b data=%h err=%b, required 001 / 12345678 / 0",
                               rsp_valid, rsp_data, rsp_err);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 || host_addr_reg !== '0) begin
            errors++; $display("FAIL single_after: valid=%b data=%h err=%b addr=%h, required all zero",
                               rsp_valid, rsp_data, rsp_err, host_addr_reg);
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_g;
        logic [15:0]     exp_a;
        apply_reset();
        for (int j = 0; j < 4; j++) begin
            exp_g = NREQ'(1 << (j % 2));
            exp_a = (j % 2 == 0) ? 16'h0100 : 16'h0200;
            @(negedge clk);
            if (j == 0) begin
                req_addr = rand_addrs(); req_addr[15:0] = 16'h0100; req_addr[31:16] = 16'h0200;
                req_valid = 3'b011;
            end
            #1;
            checks++;
            if (req_ready !== exp_g) begin
                errors++; $display("FAIL contention_grant%0d: got %b, required %b", j, req_ready, exp_g);
            end
            @(negedge clk); #1;
            checks++;
            if (reg_rd_start !== 1'b1 || host_addr_reg !== exp_a) begin
                errors++; $display("FAIL contention_issue%0d: start=%b addr=%h, required 1 / %h",
                                   j, reg_rd_start, host_addr_reg, exp_a);
            end
            @(negedge clk);
            done = 1'b1; fmac = 32'hC0DE_0000 + 32'(j); #1;
            @(negedge clk);
            done = 1'b0; #1;
            checks++;
            if (rsp_valid !== exp_g || rsp_data !== 32'hC0DE_0000 + 32'(j) || req_ready !== '0) begin
                errors++; $display("FAIL contention_resp%0d: valid=%b data=%h ready=%b, required %b / %h / 000",
                                   j, rsp_valid, rsp_data, req_ready, exp_g, 32'hC0DE_0000 + 32'(j));
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_timeout();
        logic        early;
        logic [15:0] wait_addr;
        apply_reset();
        early = 1'b0; wait_addr = '0;
        @(negedge clk);
        req_valid = 3'b010; req_addr = rand_addrs(); req_addr[31:16] = 16'h0ABC; #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL timeout_ready: got %b, required 010", req_ready);
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = '0; #1;
            if (c < 10 && rsp_valid !== '0) early = 1'b1;
            if (c == 9) wait_addr = host_addr_reg;
        end
        checks++;
        if (early !== 1'b0 || wait_addr !== 16'h0ABC) begin
            errors++; $display("FAIL timeout_wait: early_rsp=%b last_wait_addr=%h, required 0 / 0abc", early, wait_addr);
        end
        checks++;
        if (rsp_valid !== 3'b010 || rsp_data !== 32'hDEAD_BEEF || rsp_err !== 1'b1 || timeout_cnt !== 16'd1) begin
            errors++; $display("FAIL timeout_resp: valid=%b data=%h err=%b tcnt=%0d, required 010 / deadbeef / 1 / 1",
                               rsp_valid, rsp_data, rsp_err, timeout_cnt);
        end
        @(negedge clk);
        req_valid = 3'b001; req_addr[15:0] = 16'h0055; #1;
        @(negedge clk);
        req_valid = '0; #1;
        @(negedge clk);
        done = 1'b1; fmac = 32'h0BAD_F00D; #1;
        @(negedge clk);
        done = 1'b0; #1;
        checks++;
        if (rsp_valid !== 3'b001 || rsp_data !== 32'h0BAD_F00D || rsp_err !== 1'b0 || timeout_cnt !== 16'd1) begin
            errors++; $display("FAIL timeout_recover: valid=%b data=%h err=%b tcnt=%0d, required 001 / 0badf00d / 0 / 1",
                               rsp_valid, rsp_data, rsp_err, timeout_cnt);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        d = $urandom();
        @(negedge clk);
        req_valid = 3'b001; req_addr = rand_addrs(); #1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = '0;
            done = (c == 9);
            fmac = (c == 9) ? d : $urandom();
            #1;
        end
        done = 1'b0;
        checks++;
        if (rsp_valid !== 3'b001 || rsp_data !== d || rsp_err !== 1'b0 || timeout_cnt !== 16'd1) begin
            errors++; $display("FAIL collision_resp: valid=%b data=%h err=%b tcnt=%0d, required 001 / %h / 0 / 1",
                               rsp_valid, rsp_data, rsp_err, timeout_cnt, d);
        end
    endtask

    task automatic test_stray_done();
        logic bad;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = '0; done = 1'b1; fmac = $urandom(); #1;
            if (rsp_valid !== '0 || reg_rd_start !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL stray_idle: activity seen=%b, required 0", bad);
        end
        @(negedge clk);
        done = 1'b0; req_valid = 3'b100; req_addr = rand_addrs(); #1;
        checks++;
        if (req_ready !== 3'b100) begin
            errors++; $display("FAIL stray_ready: got %b, required 100", req_ready);
        end
        @(negedge clk);
        req_valid = '0; #1;
        @(negedge clk);
        done = 1'b1; fmac = 32'h7777_1111; #1;
        @(negedge clk);
        done = 1'b1; fmac = 32'h2222_8888; #1;
        checks++;
        if (rsp_valid !== 3'b100 || rsp_data !== 32'h7777_1111) begin
            errors++; $display("FAIL stray_resp: valid=%b data=%h, required 100 / 77771111", rsp_valid, rsp_data);
        end
        bad = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            done = (c == 0); #1;
            if (rsp_valid !== '0 || reg_rd_start !== 1'b0 || rsp_data !== '0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL stray_resp_done: extra activity=%b, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        apply_reset();
        @(negedge clk);
        req_valid = 3'b001; req_addr = rand_addrs(); req_addr[15:0] = 16'h0777; #1;
        @(negedge clk);
        req_valid = '0; #1;
        @(negedge clk);
        rst = 1'b1; #1;
        @(negedge clk);
        rst = 1'b0; #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0 ||
            host_addr_reg !== '0 || reg_rd_start !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: ready=%b valid=%b data=%h err=%b addr=%h start=%b, required all zero",
                               req_ready, rsp_valid, rsp_data, rsp_err, host_addr_reg, reg_rd_start);
        end
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            done = (c == 0); fmac = $urandom(); #1;
            if (rsp_valid !== '0 || reg_rd_start !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL midreset_noresp: activity=%b, required 0", bad);
        end
        @(negedge clk);
        done = 1'b0; req_valid = 3'b011; #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL midreset_priority: got %b, required 001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_random();
        int              free_at, acc, resp, done_cyc, last, owner, d, w, rvi;
        logic [15:0]     addr, tcnt, exp_addr;
        logic [31:0]     rdata, exp_data;
        logic            rerr, exp_err, exp_start;
        logic [NREQ-1:0] exp_ready, exp_rv;
        apply_reset();
        free_at = 0; acc = -100; resp = -100; done_cyc = -100; last = NREQ - 1; owner = 0;
        addr = '0; tcnt = '0; rdata = '0; rerr = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            req_addr  = rand_addrs();
            exp_ready = '0;
            rvi = int'(req_valid);
            if (k >= free_at && rvi != 0) begin
                w = -1;
                for (int off = 1; off <= NREQ; off++) begin
                    if (w < 0 && ((rvi >> ((last + off) % NREQ)) & 1) == 1) w = (last + off) % NREQ;
                end
                exp_ready = NREQ'(1 << w);
                acc = k; owner = w; last = w;
                addr = 16'(req_addr >> (16 * w));
                d = ($urandom_range(0, 1) == 0) ? 1 : int'($urandom_range(1, TIMEOUT + 1));
                done_cyc = k + 1 + d;
                if (d <= TIMEOUT) begin
                    resp = k + 2 + d; rdata = $urandom(); rerr = 1'b0;
                end else begin
                    resp = k + 2 + TIMEOUT; rdata = 32'hDEAD_BEEF; rerr = 1'b1;
                end
                free_at = resp + 1;
            end
            fmac = $urandom();
            if (k == done_cyc) begin
                done = 1'b1;
                if (!rerr) fmac = rdata;
            end else if (k >= acc + 2 && k <= resp - 1) begin
                done = 1'b0;
            end else begin
                done = ($urandom_range(0, 3) == 0);
            end
            if (k == resp && rerr && tcnt != 16'hFFFF) tcnt = tcnt + 16'd1;
            exp_start = (k == acc + 1);
            exp_addr  = (k >= acc + 1 && k <= resp - 1) ? addr : 16'h0000;
            exp_rv    = (k == resp) ? NREQ'(1 << owner) : '0;
            exp_data  = (k == resp) ? rdata : 32'h0;
            exp_err   = (k == resp) ? rerr : 1'b0;
            #1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready@%0d: got %b, required %b", k, req_ready, exp_ready);
            end
            checks++;
            if (reg_rd_start !== exp_start || host_addr_reg !== exp_addr) begin
                errors++; $display("FAIL rand_issue@%0d: start=%b addr=%h, required %b / %h",
                                   k, reg_rd_start, host_addr_reg, exp_start, exp_addr);
            end
            checks++;
            if (rsp_valid !== exp_rv || rsp_data !== exp_data || rsp_err !== exp_err) begin
                errors++; $display("FAIL rand_resp@%0d: valid=%b data=%h err=%b, required %b / %h / %b",
                                   k, rsp_valid, rsp_data, rsp_err, exp_rv, exp_data, exp_err);
            end
            checks++;
            if (timeout_cnt !== tcnt) begin
                errors++; $display("FAIL rand_tcnt@%0d: got %0d, required %0d", k, timeout_cnt, tcnt);
            end
        end
        @(negedge clk);
        req_valid = '0; done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; done = 1'b0; fmac = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_timeout();
        test_collision();
        test_stray_done();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lmac_regrd_arbiter.md
# lmac_regrd_arbiter

Shares the single LMAC register-read port (host address, read start, read done, read data) among NREQ requesters, such as a host register bridge and a statistics poller. Each read is one transaction: arbitrate round-robin, issue one start pulse with a held address, wait for done or timeout, then return data to the owner. Sits between the requesters and the MAC wrapper's register-read pins.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- TIMEOUT, 255, maximum WAIT cycles before abandoning a read (1..65535)

Ports:
- clk  in  1  single clock, shared with the MAC
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester read request; level, held until accepted
- req_addr  in  NREQ*16  per-requester address; slice i is [16*i+15:16*i]
- req_ready  out  NREQ  one-hot, one-cycle accept pulse
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse to the owner
- rsp_data  out  32  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- host_addr_reg  out  16  address to the MAC, held from ISSUE through WAIT
- reg_rd_start  out  1  one-cycle read strobe to the MAC
- reg_rd_done_out  in  1  MAC read-complete strobe
- FMAC_REGDOUT  in  32  MAC read data, sampled when done is high
- timeout_cnt  out  16  saturating count of timed-out reads

## Operation
- The FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE: if any req_valid is high, the round-robin arbiter picks winner w.
  - req_ready[w]=1 in the same cycle; this is combinational from state and the arbiter.
  - Latch addr_q=req_addr[w] and owner_q=w.
  - Next state is ISSUE.
  - If no request is pending, stay in IDLE.
- Round-robin: search starts at last_grant+1 mod NREQ. last_grant updates on each accept. After reset, last_grant=NREQ-1, so requester 0 has first priority.
- ISSUE: reg_rd_start=1, host_addr_reg=addr_q; clear the WAIT counter; go to WAIT.
- WAIT: host_addr_reg stays addr_q and reg_rd_start=0.
  - If reg_rd_done_out=1, capture data_q=FMAC_REGDOUT, set err_q=0, go to RESP.
  - Else if cnt==TIMEOUT-1, set data_q=32'hDEAD_BEEF, err_q=1, increment timeout_cnt (saturates at 16'hFFFF), go to RESP.
  - Else cnt++.
- RESP: rsp_valid[owner_q]=1, rsp_data=data_q, rsp_err=err_q; go to IDLE.
- reg_rd_done_out outside WAIT is ignored, with no state change.
- Done and timeout in the same cycle: done wins, err=0, and timeout_cnt is unchanged.
- A late done after a timeout is ignored if it arrives outside WAIT. A MAC that misses TIMEOUT is out of contract.
- Requesters may drop req_valid before acceptance with no effect. Address must be stable only in the accept cycle.
- rsp_data and rsp_err are 0 when no rsp_valid bit is high.

## Timing
- Reset values: state=IDLE, all outputs 0, host_addr_reg=0, timeout_cnt=0, last_grant=NREQ-1.
- Reset mid-transaction abandons the read immediately. No rsp_valid is generated.
- Accept at cycle t → reg_rd_start at t+1 → done earliest at t+2 → rsp_valid at t+3.
- Minimum request-to-response latency is 3 cycles. Minimum issue rate is one read per 4 cycles (IDLE, ISSUE, WAIT, RESP).
- Timeout response: rsp_valid at t+2+TIMEOUT.
- reg_rd_start, host_addr_reg, rsp_* and timeout_cnt are registered or state-decoded. req_ready is combinational from registered state plus req_valid.

## Structure
- Package lmac_regrd_pkg contains:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - ERR_DATA=32'hDEAD_BEEF;
  - ADDR_W=16 and DATA_W=32.
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: req vector, last_grant, enable;
  - outputs: one-hot grant plus binary index;
  - purely combinational;
  - reusable by other MAC-side schedulers.

## Test plan
- Single read: req_valid[0]=1, addr 16'h0040; MAC returns done at start+1 with 32'h1234_5678 → req_ready[0] at t, reg_rd_start at t+1 with addr 16'h0040, rsp_valid[0] at t+3 with data 32'h1234_5678, err=0.
- Contention: both requesters held continuously → grants alternate 0,1,0,1; each grant comes 4 cycles apart with 1-cycle done; host_addr_reg matches the owner.
- Timeout: TIMEOUT=8 and the MAC never asserts done → rsp_valid at t+10 with data 32'hDEAD_BEEF, err=1, timeout_cnt=1. A subsequent normal read succeeds.
- Done/timeout collision: done on the final WAIT cycle → err=0, captured data returned, timeout_cnt unchanged.
- Stray done during IDLE and RESP → no state change and no extra rsp_valid.
- Reset asserted in WAIT → next cycle: IDLE, all outputs 0, no response. The next request is granted to requester 0 first.
